// File: rtl/input_interrupt_controller.sv
// Multi-key input interrupt controller.
// Synchronises and debounces the key inputs and latches presses. On each
// frame tick it packs the pending presses into a 32-bit interrupt word and
// queues it in a show-ahead FIFO for the processor (valid/ack handshake).
module input_interrupt_controller #(
   parameter int         NUM_KEYS        = 4,
   parameter int         DEBOUNCE_CYCLES = 16,
   parameter int         FIFO_DEPTH      = 4,
   parameter logic [4:0] IRQ_OPCODE      = 5'h1F
) (
   input  logic                            proc_clk,
   input  logic                            reset,
   input  logic [NUM_KEYS-1:0]             keys,
   input  logic                            frame_rt_clk,
   input  logic                            irq_ack,
   output logic [31:0]                     interrupt_instruction,
   output logic                            irq_valid,
   output logic [NUM_KEYS-1:0]             pending_mask,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic [NUM_KEYS-1:0] key_sync1_reg;
   logic [NUM_KEYS-1:0] key_sync2_reg;
   logic [NUM_KEYS-1:0] key_deb;
   logic [NUM_KEYS-1:0] key_deb_prev_reg;
   logic [NUM_KEYS-1:0] pending_reg;
   logic [NUM_KEYS-1:0] pending_next;
   logic [NUM_KEYS-1:0] press;

   logic                frame_sync1_reg;
   logic                frame_sync2_reg;
   logic                frame_prev_reg;
   logic                tick;
   logic [10:0]         frame_cnt_reg;

   logic [31:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0]    count_reg;
   logic                overflow_reg;

   logic                fifo_full;
   logic                fifo_empty;
   logic                want_push;
   logic                push;
   logic                pop;
   logic                drop;
   logic [31:0]         word;

   // Two-flop synchronisers for the keys and the frame-rate square wave
   always_ff @(posedge proc_clk) begin
      if (reset) begin
         key_sync1_reg   <= '0;
         key_sync2_reg   <= '0;
         frame_sync1_reg <= 1'b0;
         frame_sync2_reg <= 1'b0;
      end else begin
         key_sync1_reg   <= keys;
         key_sync2_reg   <= key_sync1_reg;
         frame_sync1_reg <= frame_rt_clk;
         frame_sync2_reg <= frame_sync1_reg;
      end
   end

   // Per-key debouncer: the accepted level flips only after the synced level
   // has differed from it for DEBOUNCE_CYCLES consecutive cycles.
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_debounce
      logic            deb_bit_reg;
      logic [DB_W-1:0] deb_cnt_reg;

      // Debounce counter and accepted state for this key
      always_ff @(posedge proc_clk) begin
         if (reset) begin
            deb_bit_reg <= 1'b0;
            deb_cnt_reg <= '0;
         end else if (key_sync2_reg[gi] == deb_bit_reg) begin
            deb_cnt_reg <= '0;
         end else if (deb_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_bit_reg <= key_sync2_reg[gi];
            deb_cnt_reg <= '0;
         end else begin
            deb_cnt_reg <= deb_cnt_reg + DB_W'(1);
         end
      end

      assign key_deb[gi] = deb_bit_reg;
   end

   // Press/tick detection, FIFO control and word assembly
   always_comb begin
      press      = key_deb & ~key_deb_prev_reg;
      tick       = frame_sync2_reg & ~frame_prev_reg;
      fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
      fifo_empty = (count_reg == '0);
      pop        = ~fifo_empty & irq_ack;
      want_push  = tick & (pending_reg != '0);
      // A full FIFO still accepts the word when the head leaves in the same cycle
      push       = want_push & (~fifo_full | pop);
      drop       = want_push & fifo_full & ~pop;
      word       = {IRQ_OPCODE, frame_cnt_reg, 16'(pending_reg)};
      // Captured bits clear on push; a press landing in the tick cycle survives
      pending_next = push ? press : (pending_reg | press);
   end

   // Edge history, pending presses, frame counter, FIFO pointers and overflow flag
   always_ff @(posedge proc_clk) begin
      if (reset) begin
         key_deb_prev_reg <= '0;
         frame_prev_reg   <= 1'b0;
         pending_reg      <= '0;
         frame_cnt_reg    <= '0;
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         overflow_reg     <= 1'b0;
      end else begin
         key_deb_prev_reg <= key_deb;
         frame_prev_reg   <= frame_sync2_reg;
         pending_reg      <= pending_next;
         if (tick) frame_cnt_reg <= frame_cnt_reg + 11'd1;
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
         else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
         if (drop) overflow_reg <= 1'b1;
      end
   end

   // FIFO storage; contents beyond count_reg are don't-care, so no reset
   always_ff @(posedge proc_clk) begin
      if (push) mem[wr_ptr_reg] <= word;
   end

   assign irq_valid             = ~fifo_empty;
   assign interrupt_instruction = fifo_empty ? 32'h0 : mem[rd_ptr_reg];
   assign pending_mask          = pending_reg;
   assign fifo_count            = count_reg;
   assign overflow              = overflow_reg;

endmodule

// File: tb/tb_input_interrupt_controller.sv
// Directed bench for input_interrupt_controller (4 keys, debounce 4, FIFO depth 2).
module tb_input_interrupt_controller;

   logic        proc_clk = 1'b0;
   logic        reset;
   logic [3:0]  keys;
   logic        frame_rt_clk;
   logic        irq_ack;
   logic [31:0] interrupt_instruction;
   logic        irq_valid;
   logic [3:0]  pending_mask;
   logic [1:0]  fifo_count;
   logic        overflow;

   int n_checks = 0;
   int n_errors = 0;

   input_interrupt_controller #(
      .NUM_KEYS        (4),
      .DEBOUNCE_CYCLES (4),
      .FIFO_DEPTH      (2),
      .IRQ_OPCODE      (5'h1F)
   ) dut (
      .proc_clk              (proc_clk),
      .reset                 (reset),
      .keys                  (keys),
      .frame_rt_clk          (frame_rt_clk),
      .irq_ack               (irq_ack),
      .interrupt_instruction (interrupt_instruction),
      .irq_valid             (irq_valid),
      .pending_mask          (pending_mask),
      .fifo_count            (fifo_count),
      .overflow              (overflow)
   );

   always #5 proc_clk = ~proc_clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge proc_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   // Hold a key pattern long enough to debounce, then release it fully
   task automatic press_key(input logic [3:0] mask);
      keys = mask;
      step(8);
      keys = 4'b0000;
      step(8);
   endtask

   // One frame period: the tick (and any push) lands on the 3rd edge
   task automatic frame_pulse();
      frame_rt_clk = 1'b1;
      step(3);
      frame_rt_clk = 1'b0;
      step(3);
   endtask

   task automatic ack_one();
      $display("ack: instruction %h count %0d", interrupt_instruction, fifo_count);
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      keys         = 4'b0000;
      frame_rt_clk = 1'b0;
      irq_ack      = 1'b0;
      do_reset();

      // Reset state
      check_val("rst_instr",   interrupt_instruction, 32'h0);
      check_val("rst_valid",   32'(irq_valid), 32'h0);
      check_val("rst_pending", 32'(pending_mask), 32'h0);
      check_val("rst_count",   32'(fifo_count), 32'h0);
      check_val("rst_ovf",     32'(overflow), 32'h0);

      // 1: press latency and first word
      keys = 4'b0001;
      step(6);
      check_val("t1_pend_c6", 32'(pending_mask), 32'h0);
      step(1);
      check_val("t1_pend_c7", 32'(pending_mask), 32'h1);
      keys = 4'b0000;
      step(8);
      frame_pulse();
      check_val("t1_instr",   interrupt_instruction, 32'hF8000001);
      check_val("t1_valid",   32'(irq_valid), 32'h1);
      check_val("t1_pending", 32'(pending_mask), 32'h0);
      check_val("t1_count",   32'(fifo_count), 32'h1);
      ack_one();
      check_val("t1_valid_after_ack", 32'(irq_valid), 32'h0);
      check_val("t1_instr_empty",     interrupt_instruction, 32'h0);

      // 2: 3-cycle glitch ignored; 4-cycle pulse accepted (frame_cnt 1 then 2)
      keys = 4'b0100;
      step(3);
      keys = 4'b0000;
      step(8);
      check_val("t2_glitch_pend", 32'(pending_mask), 32'h0);
      frame_pulse();
      check_val("t2_glitch_count", 32'(fifo_count), 32'h0);
      keys = 4'b1000;
      step(4);
      keys = 4'b0000;
      step(10);
      check_val("t2_edge_pend", 32'(pending_mask), 32'h8);
      frame_pulse();
      check_val("t2_edge_instr", interrupt_instruction, 32'hF8020008);
      ack_one();

      // 3: overflow on full FIFO, pending retained, frame_cnt=3 on retry
      do_reset();
      press_key(4'b0001);
      frame_pulse();
      press_key(4'b0010);
      frame_pulse();
      check_val("t3_full_count", 32'(fifo_count), 32'h2);
      check_val("t3_head",       interrupt_instruction, 32'hF8000001);
      press_key(4'b0100);
      frame_pulse();
      check_val("t3_ovf",        32'(overflow), 32'h1);
      check_val("t3_retained",   32'(pending_mask), 32'h4);
      check_val("t3_drop_count", 32'(fifo_count), 32'h2);
      ack_one();
      check_val("t3_head2",      interrupt_instruction, 32'hF8010002);
      frame_pulse();
      check_val("t3_count_refill", 32'(fifo_count), 32'h2);
      check_val("t3_pend_clear",   32'(pending_mask), 32'h0);
      check_val("t3_ovf_sticky",   32'(overflow), 32'h1);
      ack_one();
      check_val("t3_retry_word",   interrupt_instruction, 32'hF8030004);
      ack_one();

      // 4: tick with ack in the same cycle on a full FIFO
      do_reset();
      press_key(4'b0001);
      frame_pulse();
      press_key(4'b0010);
      frame_pulse();
      press_key(4'b1000);
      frame_rt_clk = 1'b1;
      step(2);
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      frame_rt_clk = 1'b0;
      step(3);
      check_val("t4_count",   32'(fifo_count), 32'h2);
      check_val("t4_ovf",     32'(overflow), 32'h0);
      check_val("t4_pending", 32'(pending_mask), 32'h0);
      check_val("t4_head",    interrupt_instruction, 32'hF8010002);
      ack_one();
      check_val("t4_tail",    interrupt_instruction, 32'hF8020008);
      ack_one();

      // 5: frame counter wraps 2047 -> 0
      do_reset();
      for (int i = 0; i < 2047; i++) frame_pulse();
      check_val("t5_idle_count", 32'(fifo_count), 32'h0);
      press_key(4'b0001);
      frame_pulse();
      check_val("t5_cnt2047", interrupt_instruction, 32'hFFFF0001);
      ack_one();
      press_key(4'b0010);
      frame_pulse();
      check_val("t5_cnt_wrap", interrupt_instruction, 32'hF8000002);
      ack_one();

      // 6: reset with queued words and pending press
      do_reset();
      press_key(4'b0001);
      frame_pulse();
      press_key(4'b0010);
      frame_pulse();
      press_key(4'b0100);
      check_val("t6_pre_count", 32'(fifo_count), 32'h2);
      check_val("t6_pre_pend",  32'(pending_mask), 32'h4);
      reset   = 1'b1;
      irq_ack = 1'b1;
      step(1);
      check_val("t6_instr",   interrupt_instruction, 32'h0);
      check_val("t6_valid",   32'(irq_valid), 32'h0);
      check_val("t6_pending", 32'(pending_mask), 32'h0);
      check_val("t6_count",   32'(fifo_count), 32'h0);
      check_val("t6_ovf",     32'(overflow), 32'h0);
      reset = 1'b0;
      step(1);
      check_val("t6_ack_ignored", 32'(fifo_count), 32'h0);
      irq_ack = 1'b0;
      step(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
